// File: rtl/serial_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_BIT_CYCLES = 1;
  localparam int DEF_GAP_CYCLES = 2;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: pulses tick on the last cycle of every BIT_CYCLES-long
// enabled window; the count restarts from zero whenever enable drops.
module bit_tick_gen
  import serial_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int TW = clog2_min1(BIT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  assign tick = enable && (timer_q == T_LAST);

  // Next timer value: count while enabled, reload on terminal count or disable.
  always_comb begin
    timer_d = timer_q;
    if (!enable || tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Timer register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial pattern transmitter with valid/ready input handshake
// and an idle gap between frames.
//
// state | meaning
// IDLE  | waiting for a word, pronto high, saida at idle level
// SHIFT | frame bits on saida, each held BIT_CYCLES cycles
// GAP   | idle level for GAP_CYCLES cycles before accepting again
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter int   BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int   GAP_CYCLES = DEF_GAP_CYCLES,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dado,
  input  logic             valido,
  output logic             pronto,
  output logic             saida,
  output logic             bit_valido,
  output logic             fim
);

  localparam int IW = clog2_min1(WIDTH);
  localparam int GW = clog2_min1(GAP_CYCLES + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           saida_q, saida_d;
  logic           bit_valido_q, bit_valido_d;
  logic           pronto_q, pronto_d;
  logic           tick;

  bit_tick_gen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .enable(state_q == SHIFT),
    .tick  (tick)
  );

  // Next-state, datapath and output-register inputs.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (valido && pronto_q) begin
          state_d = SHIFT;
          shreg_d = dado;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (idx_q == IDX_LAST) begin
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            gap_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The bit currently being sent always sits at the exit end of shreg.
    pronto_d     = (state_d == IDLE);
    bit_valido_d = (state_d == SHIFT);
    if (state_d == SHIFT) begin
      saida_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
    end else begin
      saida_d = IDLE_LEVEL;
    end
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      saida_q      <= IDLE_LEVEL;
      bit_valido_q <= 1'b0;
      pronto_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      saida_q      <= saida_d;
      bit_valido_q <= bit_valido_d;
      pronto_q     <= pronto_d;
    end
  end

  assign pronto     = pronto_q;
  assign saida      = saida_q;
  assign bit_valido = bit_valido_q;
  // Final cycle of the last bit, decoded from registered state and timer.
  assign fim        = (state_q == SHIFT) && (idx_q == IDX_LAST) && tick;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench: three transmitter configurations share clock and reset.
//   inst 0: defaults (W=8, B=1, G=2, MSB first)
//   inst 1: W=4, B=3, G=0, LSB first
//   inst 2: W=8, B=1, G=0, MSB first
module tb_serial_pattern_tx;

  localparam int NI = 3;

  typedef struct {
    int   stamp;
    logic b;
    logic f;
  } exp_t;

  int cw [NI] = '{8, 4, 8};
  int cb [NI] = '{1, 3, 1};
  int cg [NI] = '{2, 0, 0};
  bit cm [NI] = '{1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst;
  logic       valido [NI];
  logic [7:0] dado   [NI];
  logic pronto_a, saida_a, bv_a, fim_a;
  logic pronto_b, saida_b, bv_b, fim_b;
  logic pronto_c, saida_c, bv_c, fim_c;

  exp_t sb [NI][$];
  int   e = 0;
  int   ready_e [NI];
  int   acc_cnt [NI];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  serial_pattern_tx u_a (
    .clock(clk), .reset(rst), .dado(dado[0]), .valido(valido[0]),
    .pronto(pronto_a), .saida(saida_a), .bit_valido(bv_a), .fim(fim_a)
  );

  serial_pattern_tx #(
    .WIDTH(4), .BIT_CYCLES(3), .GAP_CYCLES(0), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
  ) u_b (
    .clock(clk), .reset(rst), .dado(dado[1][3:0]), .valido(valido[1]),
    .pronto(pronto_b), .saida(saida_b), .bit_valido(bv_b), .fim(fim_b)
  );

  serial_pattern_tx #(
    .WIDTH(8), .BIT_CYCLES(1), .GAP_CYCLES(0), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
  ) u_c (
    .clock(clk), .reset(rst), .dado(dado[2]), .valido(valido[2]),
    .pronto(pronto_c), .saida(saida_c), .bit_valido(bv_c), .fim(fim_c)
  );

  // Reference model: at each rising edge decide acceptance from the frame
  // timing rules and queue every expected (bit, fim) cycle with its edge stamp.
  initial begin
    exp_t       en;
    logic [7:0] w;
    int         bi;
    for (int i = 0; i < NI; i++) begin
      ready_e[i] = 0;
      acc_cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      e++;
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          sb[i].delete();
          ready_e[i] = e + 2;
        end else if (valido[i] && e >= ready_e[i]) begin
          w = dado[i];
          for (int k = 0; k < cw[i]; k++) begin
            bi = cm[i] ? (cw[i] - 1 - k) : k;
            for (int c = 0; c < cb[i]; c++) begin
              en.stamp = e + k * cb[i] + c;
              en.b     = w[bi];
              en.f     = (k == cw[i] - 1) && (c == cb[i] - 1);
              sb[i].push_back(en);
            end
          end
          ready_e[i] = e + cw[i] * cb[i] + cg[i] + 1;
          acc_cnt[i]++;
        end
      end
    end
  end

  task automatic check(input string name, input int i, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d edge%0d got=%b want=%b", name, i, e, act, exp);
    end
  endtask

  // Monitor: every falling edge compare each instance with the scoreboard.
  initial begin
    logic ap, as, av, af;
    logic xs, xv, xf;
    exp_t en;
    forever begin
      @(negedge clk);
      if (e > 0) begin
        for (int i = 0; i < NI; i++) begin
          case (i)
            0:       begin ap = pronto_a; as = saida_a; av = bv_a; af = fim_a; end
            1:       begin ap = pronto_b; as = saida_b; av = bv_b; af = fim_b; end
            default: begin ap = pronto_c; as = saida_c; av = bv_c; af = fim_c; end
          endcase
          check("pronto", i, ap, (e + 1 >= ready_e[i]));
          while (sb[i].size() > 0 && sb[i][0].stamp < e) begin
            total++;
            bad++;
            $display("FAIL missed_bit inst%0d edge%0d got=none want=stamp%0d",
                     i, e, sb[i][0].stamp);
            void'(sb[i].pop_front());
          end
          xv = 1'b0;
          xs = 1'b0;
          xf = 1'b0;
          if (sb[i].size() > 0 && sb[i][0].stamp == e) begin
            en = sb[i].pop_front();
            xv = 1'b1;
            xs = en.b;
            xf = en.f;
          end
          check("bit_valido", i, av, xv);
          check("saida", i, as, xs);
          check("fim", i, af, xf);
        end
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a word and hold valido until the model accepts it.
  task automatic send(input int i, input logic [7:0] w);
    int c0;
    c0 = acc_cnt[i];
    dado[i]   = w;
    valido[i] = 1'b1;
    for (int t = 0; t < 200 && acc_cnt[i] == c0; t++) tick_n(1);
    if (acc_cnt[i] == c0) begin
      total++;
      bad++;
      $display("FAIL accept_timeout inst%0d got=no_accept want=accept", i);
    end
  endtask

  task automatic rand_run(input int i, input int n);
    for (int f = 0; f < n; f++) begin
      send(i, 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        valido[i] = 1'b0;
        tick_n($urandom_range(1, 6));
      end
    end
    valido[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      valido[i] = 1'b0;
      dado[i]   = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick_n(3);

    send(0, 8'b1011_0010);
    valido[0] = 1'b0;
    tick_n(14);

    send(0, 8'hFF);
    tick_n(3);
    send(0, 8'h00);
    valido[0] = 1'b0;
    tick_n(12);

    send(0, 8'h3C);
    valido[0] = 1'b0;
    tick_n(4);
    rst = 1'b1;
    tick_n(2);
    rst = 1'b0;
    tick_n(2);
    send(0, 8'hA5);
    valido[0] = 1'b0;
    tick_n(12);

    send(1, 8'h06);
    valido[1] = 1'b0;
    tick_n(16);

    send(2, 8'hF0);
    send(2, 8'h0F);
    valido[2] = 1'b0;
    tick_n(12);

    fork
      rand_run(0, 25);
      rand_run(1, 25);
      rand_run(2, 25);
    join

    for (int t = 0; t < 500 && (sb[0].size() + sb[1].size() + sb[2].size()) > 0; t++)
      tick_n(1);
    if ((sb[0].size() + sb[1].size() + sb[2].size()) > 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0", sb[0].size() + sb[1].size() + sb[2].size());
    end
    tick_n(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
